// File: rtl/hotp_truncator.sv
// Serial HMAC-SHA1 digest capture, HOTP dynamic truncation and bit-serial
// double-dabble conversion of the 31-bit result to packed BCD.
module hotp_truncator #(
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  digest_valid,
    input  logic                  digest_bit,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic [3:0]            offset
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CAPTURE = 3'd1;
    localparam logic [2:0] ST_SELECT  = 3'd2;
    localparam logic [2:0] ST_CONVERT = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]          state_reg;
    logic [7:0]          bit_cnt_reg;
    logic [159:0]        d_reg;
    logic [30:0]         bin_reg;
    logic [39:0]         bcd_reg;
    logic [4:0]          iter_reg;
    logic [3:0]          off_reg;
    logic [4*DIGITS-1:0] digits_reg;
    logic [3:0]          offset_reg;

    logic [7:0]          sel_lsb;
    logic [30:0]         p_sel;
    logic [39:0]         bcd_adj;
    logic [39:0]         bcd_next;
    logic [30:0]         bin_next;

    // Bytes off..off+3 occupy D[158-8*off+1 : 128-8*off]; the MSB is dropped.
    assign sel_lsb = 8'd128 - {1'b0, d_reg[3:0], 3'b000};
    assign p_sel   = d_reg[sel_lsb +: 31];

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_dabble
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                        ? bcd_reg[gi*4 +: 4] + 4'd3
                                        : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    assign {bcd_next, bin_next} = {bcd_adj, bin_reg} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            d_reg       <= '0;
            bin_reg     <= '0;
            bcd_reg     <= '0;
            iter_reg    <= '0;
            off_reg     <= '0;
            digits_reg  <= '0;
            offset_reg  <= '0;
        end else if (start) begin
            state_reg   <= ST_CAPTURE;
            bit_cnt_reg <= '0;
            d_reg       <= '0;
            bin_reg     <= '0;
            bcd_reg     <= '0;
            iter_reg    <= '0;
            off_reg     <= '0;
            digits_reg  <= '0;
            offset_reg  <= '0;
        end else begin
            case (state_reg)
                ST_CAPTURE: begin
                    if (digest_valid) begin
                        d_reg       <= {d_reg[158:0], digest_bit};
                        bit_cnt_reg <= bit_cnt_reg + 8'd1;
                        if (bit_cnt_reg == 8'd159) begin
                            state_reg <= ST_SELECT;
                        end
                    end
                end
                ST_SELECT: begin
                    off_reg   <= d_reg[3:0];
                    bin_reg   <= p_sel;
                    bcd_reg   <= '0;
                    iter_reg  <= '0;
                    state_reg <= ST_CONVERT;
                end
                ST_CONVERT: begin
                    bcd_reg <= bcd_next;
                    bin_reg <= bin_next;
                    if (iter_reg == 5'd30) begin
                        // Outputs load straight from the final iteration.
                        digits_reg <= bcd_next[4*DIGITS-1:0];
                        offset_reg <= off_reg;
                        state_reg  <= ST_DONE;
                    end else begin
                        iter_reg <= iter_reg + 5'd1;
                    end
                end
                ST_IDLE, ST_DONE: begin
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy   = (state_reg == ST_CAPTURE) || (state_reg == ST_SELECT) ||
                    (state_reg == ST_CONVERT);
    assign done   = (state_reg == ST_DONE);
    assign digits = digits_reg;
    assign offset = offset_reg;

endmodule

// File: tb/tb_hotp_truncator.sv
// Scoreboard bench for hotp_truncator: two instances (6 and 8 digits) share
// stimulus; a negedge monitor pops reference results when done rises.
module tb_hotp_truncator;

    localparam int T = 10;

    logic clk = 1'b0;
    logic rst, start, digest_valid, digest_bit;
    logic busy6, done6, busy8, done8;
    logic [23:0] digits6;
    logic [31:0] digits8;
    logic [3:0]  offset6, offset8;

    always #(T/2) clk = ~clk;

    hotp_truncator #(.DIGITS(6)) dut6 (
        .clk(clk), .rst(rst), .start(start), .digest_valid(digest_valid),
        .digest_bit(digest_bit), .busy(busy6), .done(done6),
        .digits(digits6), .offset(offset6)
    );

    hotp_truncator #(.DIGITS(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .digest_valid(digest_valid),
        .digest_bit(digest_bit), .busy(busy8), .done(done8),
        .digits(digits8), .offset(offset8)
    );

    typedef struct {
        logic [3:0]  off;
        logic [23:0] d6;
        logic [31:0] d8;
        time         e0;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    time  last_edge = 0;

    localparam logic [159:0] DG_CNT0 = 160'hcc93cf18508d94934c64b65d8ba7667fb7cde4b0;
    localparam logic [159:0] DG_CNT1 = 160'h75a48a19d4cbe100644e8ac1397eea747a2d33ab;
    localparam logic [159:0] DG_EX   = 160'h1f8698690e02ca16618550ef7f19da8e945b555a;
    localparam logic [159:0] DG_O15  = 160'h00000000_00000000_00000000_000000ff_ffffff0f;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference: RFC 4226 dynamic truncation on digest bytes, then decimal digits.
    function automatic exp_t model(input logic [159:0] d, input time e0);
        exp_t        e;
        logic [31:0] p;
        logic [7:0]  b;
        int          k;
        p = '0;
        e.off = d[3:0];
        for (int j = 0; j < 4; j++) begin
            k = int'(e.off) + j;
            b = d[159 - 8*k -: 8];
            p = {p[23:0], b};
        end
        p[31] = 1'b0;
        e.d6 = to_bcd(p % 1000000)[23:0];
        e.d8 = to_bcd(p % 100000000);
        e.e0 = e0;
        return e;
    endfunction

    logic done6_q = 1'b0;
    logic busy6_q = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        check("busy_done_exclusive", {63'd0, busy6 & done6}, 64'd0);
        if (done6 && !done6_q) begin
            if (q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                $display("result: off=%0d digits6=%06h digits8=%08h", offset6, digits6, digits8);
                check("offset6", {60'd0, offset6}, {60'd0, e.off});
                check("digits6", {40'd0, digits6}, {40'd0, e.d6});
                check("offset8", {60'd0, offset8}, {60'd0, e.off});
                check("digits8", {32'd0, digits8}, {32'd0, e.d8});
                check("latency", 64'($time - e.e0), 64'(32*T + T/2));
                check("busy_before_done", {63'd0, busy6_q}, 64'd1);
                check("done8_sync", {63'd0, done8}, 64'd1);
            end
        end
        done6_q = done6;
        busy6_q = busy6;
    end

    task automatic send_bit(input logic b);
        digest_valid = 1'b1;
        digest_bit   = b;
        @(posedge clk);
        last_edge = $time;
        @(negedge clk);
        digest_valid = 1'b0;
    endtask

    task automatic send_digest(input logic [159:0] d, input int maxgap);
        for (int i = 159; i >= 0; i--) begin
            repeat ($urandom_range(maxgap, 0)) @(negedge clk);
            send_bit(d[i]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        digest_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {63'd0, busy6}, 64'd1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done6) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run(input logic [159:0] d, input int maxgap);
        pulse_start();
        send_digest(d, maxgap);
        q.push_back(model(d, last_edge));
        wait_done();
    endtask

    initial begin
        #(4_000_000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; digest_valid = 1'b0; digest_bit = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {63'd0, busy6}, 64'd0);
        check("rst_done", {63'd0, done6}, 64'd0);
        check("rst_digits6", {40'd0, digits6}, 64'd0);
        check("rst_offset6", {60'd0, offset6}, 64'd0);
        check("rst_digits8", {32'd0, digits8}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // RFC 4226 count 0, back-to-back
        run(DG_CNT0, 0);
        check("rfc0_offset", {60'd0, offset6}, 64'd0);
        check("rfc0_digits", {40'd0, digits6}, 64'h755224);

        // RFC 4226 worked example with gaps
        run(DG_EX, 3);
        check("ex_offset", {60'd0, offset6}, 64'd10);
        check("ex_digits", {40'd0, digits6}, 64'h872921);

        // Offset 15 boundary
        run(DG_O15, 1);
        check("o15_offset", {60'd0, offset6}, 64'd15);
        check("o15_digits6", {40'd0, digits6}, 64'h483647);
        check("o15_digits8", {32'd0, digits8}, 64'h47483647);

        // Abort mid-capture; start wins over a same-cycle digest bit
        pulse_start();
        for (int i = 159; i >= 60; i--) send_bit(DG_CNT0[i]);
        start = 1'b1; digest_valid = 1'b1; digest_bit = 1'b1;
        @(negedge clk);
        start = 1'b0; digest_valid = 1'b0;
        send_digest(DG_CNT1, 0);
        q.push_back(model(DG_CNT1, last_edge));
        wait_done();
        check("abort_offset", {60'd0, offset6}, 64'd11);
        check("abort_digits", {40'd0, digits6}, 64'h287082);

        // Randomised digests with random gaps
        for (int t = 0; t < 5; t++) begin
            logic [159:0] rd;
            rd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            run(rd, t % 4);
        end

        // Reset mid-CONVERT
        pulse_start();
        send_digest(DG_EX, 0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {63'd0, busy6}, 64'd0);
        check("midrst_done", {63'd0, done6}, 64'd0);
        check("midrst_digits", {40'd0, digits6}, 64'd0);
        for (int i = 0; i < 200; i++) send_bit(1'($urandom));
        repeat (40) @(negedge clk);
        check("idle_busy", {63'd0, busy6}, 64'd0);
        check("idle_done", {63'd0, done6}, 64'd0);
        check("idle_digits", {40'd0, digits6}, 64'd0);
        check("idle_offset", {60'd0, offset6}, 64'd0);

        // Hold behaviour after done
        run(DG_CNT0, 0);
        for (int i = 0; i < 300; i++) begin
            digest_valid = 1'($urandom);
            digest_bit   = 1'($urandom);
            @(negedge clk);
            if (i % 30 == 29) begin
                check("hold_digits", {40'd0, digits6}, 64'h755224);
                check("hold_offset", {60'd0, offset6}, 64'd0);
                check("hold_done", {63'd0, done6}, 64'd1);
            end
        end
        digest_valid = 1'b0;
        pulse_start();
        check("restart_done", {63'd0, done6}, 64'd0);
        check("restart_digits", {40'd0, digits6}, 64'd0);
        repeat (5) @(negedge clk);
        check("queue_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
